scr1_memif_arb: RTL and testbench

//  Shares one core-side memory interface (memif req/ack/resp) between the IMEM and DMEM

---
 rtl/scr1_memif_arb.sv | 175 +++++++++++++++++
 tb/tb_scr1_memif_arb.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scr1_memif_arb.sv
// IMEM/DMEM arbiter sharing one memif port toward a single AHB bridge, with an
// owner-ID ordering FIFO for in-order response routing. Optional: SCR1_MEMIF_ARB_RR_EN (round-robin).

package scr1_memif_pkg;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

endpackage

module scr1_memif_arb
  import scr1_memif_pkg::*;
#(
  parameter int SCR1_ARB_DEPTH = 4,
  parameter int SCR1_ARB_CNT_W = $clog2(SCR1_ARB_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // IMEM requester
  input  logic                 imem_req,
  input  type_scr1_mem_cmd_e   imem_cmd,
  input  logic [31:0]          imem_addr,
  output logic                 imem_req_ack,
  output logic [31:0]          imem_rdata,
  output type_scr1_mem_resp_e  imem_resp,
  // DMEM requester
  input  logic                 dmem_req,
  input  type_scr1_mem_cmd_e   dmem_cmd,
  input  type_scr1_mem_width_e dmem_width,
  input  logic [31:0]          dmem_addr,
  input  logic [31:0]          dmem_wdata,
  output logic                 dmem_req_ack,
  output logic [31:0]          dmem_rdata,
  output type_scr1_mem_resp_e  dmem_resp,
  // Shared bridge side
  output logic                 mem_req,
  output type_scr1_mem_cmd_e   mem_cmd,
  output type_scr1_mem_width_e mem_width,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic                 mem_req_ack,
  input  logic [31:0]          mem_rdata,
  input  type_scr1_mem_resp_e  mem_resp
);

  localparam int PTR_W = (SCR1_ARB_DEPTH > 1) ? $clog2(SCR1_ARB_DEPTH) : 1;
  localparam logic [PTR_W-1:0]          PTR_LAST = PTR_W'(SCR1_ARB_DEPTH - 1);
  localparam logic [SCR1_ARB_CNT_W-1:0] CNT_FULL = SCR1_ARB_CNT_W'(SCR1_ARB_DEPTH);
  localparam logic OWNER_IMEM = 1'b0;
  localparam logic OWNER_DMEM = 1'b1;

  logic                      owner_q [SCR1_ARB_DEPTH];
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic [SCR1_ARB_CNT_W-1:0] cnt;
  logic                      lock;
  logic                      locked_sel;

  logic sel;
  logic policy_sel;
  logic lock_hold;
  logic full;
  logic empty;
  logic accept;
  logic pop;
  logic head_owner;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
  endfunction

`ifdef SCR1_MEMIF_ARB_RR_EN
  logic last_gnt;

  // Alternate only on contention; a lone requester is always served.
  always_comb begin
    if (imem_req & dmem_req) policy_sel = ~last_gnt;
    else                     policy_sel = dmem_req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= OWNER_IMEM;
    end else if (accept) begin
      last_gnt <= sel;
    end
  end
`else
  // Fixed priority: DMEM wins whenever it asks.
  assign policy_sel = dmem_req;
`endif

  // A held request keeps the grant; if its owner withdraws, the lock is released at once.
  assign lock_hold = lock & ((locked_sel == OWNER_DMEM) ? dmem_req : imem_req);
  assign sel       = lock_hold ? locked_sel : policy_sel;

  assign full   = (cnt == CNT_FULL);
  assign empty  = (cnt == '0);
  assign accept = mem_req & mem_req_ack;
  assign pop    = (mem_resp != SCR1_MEM_RESP_NOTRDY) & ~empty;

  assign mem_req   = rst_n & (imem_req | dmem_req) & ~full;
  assign mem_cmd   = (sel == OWNER_DMEM) ? dmem_cmd   : imem_cmd;
  assign mem_width = (sel == OWNER_DMEM) ? dmem_width : SCR1_MEM_WIDTH_WORD;
  assign mem_addr  = (sel == OWNER_DMEM) ? dmem_addr  : imem_addr;
  assign mem_wdata = (sel == OWNER_DMEM) ? dmem_wdata : 32'h0;

  assign imem_req_ack = accept & (sel == OWNER_IMEM);
  assign dmem_req_ack = accept & (sel == OWNER_DMEM);

  assign head_owner = owner_q[rd_ptr];
  assign imem_rdata = mem_rdata;
  assign dmem_rdata = mem_rdata;
  assign imem_resp  = (pop & (head_owner == OWNER_IMEM)) ? mem_resp : SCR1_MEM_RESP_NOTRDY;
  assign dmem_resp  = (pop & (head_owner == OWNER_DMEM)) ? mem_resp : SCR1_MEM_RESP_NOTRDY;

  // Owner storage carries no reset; validity is tracked by cnt and the pointers.
  always_ff @(posedge clk) begin
    if (accept) begin
      owner_q[wr_ptr] <= sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      lock       <= 1'b0;
      locked_sel <= OWNER_IMEM;
    end else begin
      if (accept) wr_ptr <= ptr_next(wr_ptr);
      if (pop)    rd_ptr <= ptr_next(rd_ptr);

      case ({accept, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase

      if (accept) begin
        lock <= 1'b0;
      end else if (mem_req) begin
        lock       <= 1'b1;
        locked_sel <= sel;
      end else begin
        lock <= 1'b0;
      end
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst_n && (mem_resp != SCR1_MEM_RESP_NOTRDY)) begin
      assert (!empty)
        else $error("scr1_memif_arb: response received with no outstanding transfer");
    end
  end
`endif

endmodule

// File: tb/tb_scr1_memif_arb.sv
// Directed self-checking bench for scr1_memif_arb (either arbitration build).

module tb_scr1_memif_arb;
  import scr1_memif_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                 imem_req;
  type_scr1_mem_cmd_e   imem_cmd;
  logic [31:0]          imem_addr;
  logic                 imem_req_ack;
  logic [31:0]          imem_rdata;
  type_scr1_mem_resp_e  imem_resp;
  logic                 dmem_req;
  type_scr1_mem_cmd_e   dmem_cmd;
  type_scr1_mem_width_e dmem_width;
  logic [31:0]          dmem_addr;
  logic [31:0]          dmem_wdata;
  logic                 dmem_req_ack;
  logic [31:0]          dmem_rdata;
  type_scr1_mem_resp_e  dmem_resp;
  logic                 mem_req;
  type_scr1_mem_cmd_e   mem_cmd;
  type_scr1_mem_width_e mem_width;
  logic [31:0]          mem_addr;
  logic [31:0]          mem_wdata;
  logic                 mem_req_ack;
  logic [31:0]          mem_rdata;
  type_scr1_mem_resp_e  mem_resp;

  int checks = 0;
  int errors = 0;

  scr1_memif_arb dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_cmd     (imem_cmd),
    .imem_addr    (imem_addr),
    .imem_req_ack (imem_req_ack),
    .imem_rdata   (imem_rdata),
    .imem_resp    (imem_resp),
    .dmem_req     (dmem_req),
    .dmem_cmd     (dmem_cmd),
    .dmem_width   (dmem_width),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_req_ack (dmem_req_ack),
    .dmem_rdata   (dmem_rdata),
    .dmem_resp    (dmem_resp),
    .mem_req      (mem_req),
    .mem_cmd      (mem_cmd),
    .mem_width    (mem_width),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_req_ack  (mem_req_ack),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_req    = 1'b0;
    imem_cmd    = SCR1_MEM_CMD_RD;
    imem_addr   = 32'h0;
    dmem_req    = 1'b0;
    dmem_cmd    = SCR1_MEM_CMD_RD;
    dmem_width  = SCR1_MEM_WIDTH_WORD;
    dmem_addr   = 32'h0;
    dmem_wdata  = 32'h0;
    mem_req_ack = 1'b0;
    mem_rdata   = 32'h0;
    mem_resp    = SCR1_MEM_RESP_NOTRDY;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n    = 1'b0;
    imem_req = 1'b1;
    dmem_req = 1'b1;
    mem_req_ack = 1'b1;
    tick();
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got=%0b exp=0", mem_req); end
    checks++; if (imem_req_ack !== 1'b0 || dmem_req_ack !== 1'b0) begin errors++; $display("FAIL reset_acks got=%0b%0b exp=00", imem_req_ack, dmem_req_ack); end
    checks++; if (imem_resp !== SCR1_MEM_RESP_NOTRDY || dmem_resp !== SCR1_MEM_RESP_NOTRDY) begin errors++; $display("FAIL reset_resp got=%0d/%0d exp=0/0", imem_resp, dmem_resp); end
    checks++; if (dut.cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", dut.cnt); end
    tick();
    idle_inputs();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_imem_reads();
    for (int i = 0; i < 4; i++) begin
      imem_req    = (i < 3);
      imem_addr   = 32'h100 + 32'(4 * i);
      mem_req_ack = 1'b1;
      mem_resp    = (i > 0) ? SCR1_MEM_RESP_RDY_OK : SCR1_MEM_RESP_NOTRDY;
      mem_rdata   = 32'hA0 + 32'(i);
      @(negedge clk);
      if (i < 3) begin
        checks++; if (imem_req_ack !== 1'b1 || mem_addr !== 32'h100 + 32'(4 * i)) begin errors++; $display("FAIL imem_req%0d ack=%0b addr=%h exp ack=1 addr=%h", i, imem_req_ack, mem_addr, 32'h100 + 32'(4 * i)); end
        checks++; if (mem_width !== SCR1_MEM_WIDTH_WORD || mem_wdata !== 32'h0) begin errors++; $display("FAIL imem_width%0d got=%0d/%h exp=2/0", i, mem_width, mem_wdata); end
      end
      if (i > 0) begin
        checks++; if (imem_resp !== SCR1_MEM_RESP_RDY_OK || imem_rdata !== 32'hA0 + 32'(i)) begin errors++; $display("FAIL imem_resp%0d got=%0d/%h exp=1/%h", i, imem_resp, imem_rdata, 32'hA0 + 32'(i)); end
        checks++; if (dmem_resp !== SCR1_MEM_RESP_NOTRDY) begin errors++; $display("FAIL imem_dresp%0d got=%0d exp=0", i, dmem_resp); end
      end
      tick();
    end
    idle_inputs();
    @(negedge clk);
    checks++; if (dut.cnt !== 3'd0) begin errors++; $display("FAIL imem_cnt got=%0d exp=0", dut.cnt); end
    tick();
  endtask

  task automatic test_priority();
    logic exp_o [3];
`ifdef SCR1_MEMIF_ARB_RR_EN
    exp_o[0] = 1'b1; exp_o[1] = 1'b0; exp_o[2] = 1'b1;
`else
    exp_o[0] = 1'b1; exp_o[1] = 1'b1; exp_o[2] = 1'b1;
`endif
    for (int k = 0; k < 3; k++) begin
      imem_req = 1'b1; imem_addr = 32'h400 + 32'(4 * k);
      dmem_req = 1'b1; dmem_addr = 32'h800 + 32'(4 * k);
      mem_req_ack = 1'b1;
      @(negedge clk);
      checks++; if (dmem_req_ack !== exp_o[k] || imem_req_ack !== ~exp_o[k]) begin errors++; $display("FAIL prio_ack%0d got i=%0b d=%0b exp d=%0b", k, imem_req_ack, dmem_req_ack, exp_o[k]); end
      checks++; if (mem_addr !== (exp_o[k] ? 32'h800 : 32'h400) + 32'(4 * k)) begin errors++; $display("FAIL prio_addr%0d got=%h", k, mem_addr); end
      tick();
    end
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      mem_resp = SCR1_MEM_RESP_RDY_OK; mem_rdata = 32'hB0 + 32'(k);
      @(negedge clk);
      checks++; if (imem_resp !== (exp_o[k] ? SCR1_MEM_RESP_NOTRDY : SCR1_MEM_RESP_RDY_OK) || dmem_resp !== (exp_o[k] ? SCR1_MEM_RESP_RDY_OK : SCR1_MEM_RESP_NOTRDY)) begin errors++; $display("FAIL prio_route%0d got i=%0d d=%0d exp owner=%0b", k, imem_resp, dmem_resp, exp_o[k]); end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_lock();
    logic exp_o [3];
    exp_o[0] = 1'b1; exp_o[1] = 1'b0; exp_o[2] = 1'b1;
    // DMEM write held while bridge stalls, IMEM joins during the stall
    dmem_req = 1'b1; dmem_cmd = SCR1_MEM_CMD_WR; dmem_width = SCR1_MEM_WIDTH_HWORD;
    dmem_addr = 32'h2000; dmem_wdata = 32'hDEAD;
    imem_addr = 32'h300;
    for (int c = 0; c < 4; c++) begin
      imem_req    = (c > 0);
      mem_req_ack = (c == 3);
      @(negedge clk);
      checks++; if (mem_addr !== 32'h2000 || mem_cmd !== SCR1_MEM_CMD_WR || mem_wdata !== 32'hDEAD || mem_width !== SCR1_MEM_WIDTH_HWORD) begin errors++; $display("FAIL lock_d_hold%0d addr=%h cmd=%0d exp addr=2000 cmd=1", c, mem_addr, mem_cmd); end
      checks++; if (dmem_req_ack !== (c == 3) || imem_req_ack !== 1'b0) begin errors++; $display("FAIL lock_d_ack%0d got i=%0b d=%0b exp d=%0b", c, imem_req_ack, dmem_req_ack, (c == 3)); end
      tick();
    end
    // IMEM locked first; DMEM arrival must not steal the grant
    dmem_req = 1'b0; dmem_cmd = SCR1_MEM_CMD_RD; dmem_addr = 32'h2004;
    for (int c = 0; c < 3; c++) begin
      imem_req    = 1'b1;
      dmem_req    = (c > 0);
      mem_req_ack = (c == 2);
      @(negedge clk);
      checks++; if (mem_addr !== 32'h300 || mem_width !== SCR1_MEM_WIDTH_WORD) begin errors++; $display("FAIL lock_i_hold%0d addr=%h exp=300", c, mem_addr); end
      checks++; if (imem_req_ack !== (c == 2) || dmem_req_ack !== 1'b0) begin errors++; $display("FAIL lock_i_ack%0d got i=%0b d=%0b exp i=%0b", c, imem_req_ack, dmem_req_ack, (c == 2)); end
      tick();
    end
    imem_req = 1'b0;
    @(negedge clk);
    checks++; if (dmem_req_ack !== 1'b1 || mem_addr !== 32'h2004) begin errors++; $display("FAIL lock_after ack=%0b addr=%h exp ack=1 addr=2004", dmem_req_ack, mem_addr); end
    tick();
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      mem_resp = SCR1_MEM_RESP_RDY_OK;
      @(negedge clk);
      checks++; if (dmem_resp !== (exp_o[k] ? SCR1_MEM_RESP_RDY_OK : SCR1_MEM_RESP_NOTRDY) || imem_resp !== (exp_o[k] ? SCR1_MEM_RESP_NOTRDY : SCR1_MEM_RESP_RDY_OK)) begin errors++; $display("FAIL lock_route%0d got i=%0d d=%0d exp owner=%0b", k, imem_resp, dmem_resp, exp_o[k]); end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_full();
    logic own [4];
    own[0] = 1'b0; own[1] = 1'b1; own[2] = 1'b1; own[3] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      imem_req = ~own[k]; dmem_req = own[k]; mem_req_ack = 1'b1;
      @(negedge clk);
      checks++; if (dmem_req_ack !== own[k] || imem_req_ack !== ~own[k]) begin errors++; $display("FAIL full_push%0d got i=%0b d=%0b exp d=%0b", k, imem_req_ack, dmem_req_ack, own[k]); end
      tick();
    end
    // Full with a same-cycle pop: still no request
    imem_req = 1'b1; dmem_req = 1'b1; mem_req_ack = 1'b1;
    mem_resp = SCR1_MEM_RESP_RDY_OK; mem_rdata = 32'hC0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0 || imem_req_ack !== 1'b0 || dmem_req_ack !== 1'b0) begin errors++; $display("FAIL full_block req=%0b acks=%0b%0b exp 0/00", mem_req, imem_req_ack, dmem_req_ack); end
    checks++; if (dut.cnt !== 3'd4) begin errors++; $display("FAIL full_cnt got=%0d exp=4", dut.cnt); end
    checks++; if (imem_resp !== SCR1_MEM_RESP_RDY_OK || dmem_resp !== SCR1_MEM_RESP_NOTRDY) begin errors++; $display("FAIL full_route0 got i=%0d d=%0d exp i=1 d=0", imem_resp, dmem_resp); end
    tick();
    imem_req = 1'b0; dmem_req = 1'b0;
    for (int k = 1; k < 4; k++) begin
      mem_rdata = 32'hC0 + 32'(k);
      @(negedge clk);
      checks++; if (dmem_resp !== (own[k] ? SCR1_MEM_RESP_RDY_OK : SCR1_MEM_RESP_NOTRDY) || imem_resp !== (own[k] ? SCR1_MEM_RESP_NOTRDY : SCR1_MEM_RESP_RDY_OK)) begin errors++; $display("FAIL full_route%0d got i=%0d d=%0d exp owner=%0b", k, imem_resp, dmem_resp, own[k]); end
      tick();
    end
    idle_inputs();
    @(negedge clk);
    checks++; if (dut.cnt !== 3'd0) begin errors++; $display("FAIL full_drain_cnt got=%0d exp=0", dut.cnt); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic push_o [6];
    logic pop_o  [6];
    push_o[0] = 0; push_o[1] = 1; push_o[2] = 1; push_o[3] = 0; push_o[4] = 0; push_o[5] = 1;
    pop_o[0]  = 0; pop_o[1]  = 1; pop_o[2]  = 0; pop_o[3]  = 1; pop_o[4]  = 1; pop_o[5]  = 0;
    mem_req_ack = 1'b1;
    imem_req = 1'b1; tick();
    imem_req = 1'b0; dmem_req = 1'b1; tick();
    for (int s = 0; s < 6; s++) begin
      imem_req = ~push_o[s]; dmem_req = push_o[s];
      mem_resp = SCR1_MEM_RESP_RDY_OK; mem_rdata = 32'hD0 + 32'(s);
      @(negedge clk);
      checks++; if (dut.cnt !== 3'd2) begin errors++; $display("FAIL b2b_cnt%0d got=%0d exp=2", s, dut.cnt); end
      checks++; if (dmem_req_ack !== push_o[s] || imem_req_ack !== ~push_o[s]) begin errors++; $display("FAIL b2b_ack%0d got i=%0b d=%0b exp d=%0b", s, imem_req_ack, dmem_req_ack, push_o[s]); end
      checks++; if (dmem_resp !== (pop_o[s] ? SCR1_MEM_RESP_RDY_OK : SCR1_MEM_RESP_NOTRDY) || imem_resp !== (pop_o[s] ? SCR1_MEM_RESP_NOTRDY : SCR1_MEM_RESP_RDY_OK) || dmem_rdata !== 32'hD0 + 32'(s)) begin errors++; $display("FAIL b2b_route%0d got i=%0d d=%0d exp owner=%0b", s, imem_resp, dmem_resp, pop_o[s]); end
      tick();
    end
    imem_req = 1'b0; dmem_req = 1'b0; mem_req_ack = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++; if (imem_resp !== (k == 0 ? SCR1_MEM_RESP_RDY_OK : SCR1_MEM_RESP_NOTRDY) || dmem_resp !== (k == 0 ? SCR1_MEM_RESP_NOTRDY : SCR1_MEM_RESP_RDY_OK)) begin errors++; $display("FAIL b2b_drain%0d got i=%0d d=%0d", k, imem_resp, dmem_resp); end
      tick();
    end
    idle_inputs();
    @(negedge clk);
    checks++; if (dut.cnt !== 3'd0) begin errors++; $display("FAIL b2b_end_cnt got=%0d exp=0", dut.cnt); end
    tick();
  endtask

  task automatic test_err_reset();
    dmem_req = 1'b1; dmem_cmd = SCR1_MEM_CMD_WR; mem_req_ack = 1'b1;
    tick();
    idle_inputs();
    mem_resp = SCR1_MEM_RESP_RDY_ER;
    @(negedge clk);
    checks++; if (dmem_resp !== SCR1_MEM_RESP_RDY_ER || imem_resp !== SCR1_MEM_RESP_NOTRDY) begin errors++; $display("FAIL err_route got i=%0d d=%0d exp i=0 d=2", imem_resp, dmem_resp); end
    tick();
    mem_resp = SCR1_MEM_RESP_NOTRDY;
    @(negedge clk);
    checks++; if (dut.cnt !== 3'd0) begin errors++; $display("FAIL err_pop_cnt got=%0d exp=0", dut.cnt); end
    // Two outstanding (I then D), then reset mid-flight
    mem_req_ack = 1'b1;
    tick(); imem_req = 1'b1;
    tick(); imem_req = 1'b0; dmem_req = 1'b1;
    tick(); idle_inputs();
    @(negedge clk);
    checks++; if (dut.cnt !== 3'd2) begin errors++; $display("FAIL rst_pre_cnt got=%0d exp=2", dut.cnt); end
    tick();
    imem_req = 1'b1; mem_req_ack = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++; if (dut.cnt !== 3'd0 || mem_req !== 1'b0 || imem_req_ack !== 1'b0) begin errors++; $display("FAIL rst_mid cnt=%0d req=%0b ack=%0b exp 0/0/0", dut.cnt, mem_req, imem_req_ack); end
    tick();
    rst_n = 1'b1;
    imem_req = 1'b0; dmem_req = 1'b1; dmem_cmd = SCR1_MEM_CMD_RD;
    @(negedge clk);
    checks++; if (dmem_req_ack !== 1'b1) begin errors++; $display("FAIL rst_after_ack got=%0b exp=1", dmem_req_ack); end
    tick();
    idle_inputs();
    mem_resp = SCR1_MEM_RESP_RDY_OK;
    @(negedge clk);
    checks++; if (dmem_resp !== SCR1_MEM_RESP_RDY_OK || imem_resp !== SCR1_MEM_RESP_NOTRDY) begin errors++; $display("FAIL rst_after_route got i=%0d d=%0d exp i=0 d=1", imem_resp, dmem_resp); end
    tick();
    idle_inputs();
    @(negedge clk);
    checks++; if (dut.cnt !== 3'd0) begin errors++; $display("FAIL rst_end_cnt got=%0d exp=0", dut.cnt); end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_imem_reads();
    test_priority();
    test_lock();
    test_full();
    test_back_to_back();
    test_err_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
